// File: rtl/mig_chain_eval_pkg.sv
// Shared types and constants for the sequential majority-inverter-graph evaluator.
package mig_pkg;

  localparam int N_IN    = 6;
  localparam int N_NODES = 8;
  localparam int SEL_W   = $clog2(1 + N_IN + N_NODES);
  localparam int LEN_W   = $clog2(N_NODES + 1);
  localparam int ADDR_W  = $clog2(N_NODES);
  localparam int WORD_W  = 3 * (SEL_W + 1);

  localparam logic [SEL_W-1:0] SEL_CONST0 = '0;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_e;

  typedef struct packed {
    logic             inv;
    logic [SEL_W-1:0] sel;
  } operand_t;

  // op[2] occupies the most significant field: {inv2,sel2,inv1,sel1,inv0,sel0}
  typedef struct packed {
    operand_t [2:0] op;
  } node_word_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mig_chain_eval_if.sv
// Program, configuration and valid/ready bus of the MIG chain evaluator.
interface mig_chain_eval_if;
  import mig_pkg::*;

  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [WORD_W-1:0] prog_data;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_out_inv;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   x;
  logic              out_valid;
  logic              out_ready;
  logic              y;
  logic              err_fwd;

  modport slave (
    input  prog_we, prog_addr, prog_data, cfg_len, cfg_out_inv,
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, err_fwd
  );

  modport master (
    output prog_we, prog_addr, prog_data, cfg_len, cfg_out_inv,
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, err_fwd
  );

endinterface

// File: rtl/mig_chain_eval_operand_mux.sv
// Resolves one operand select against {nodes, x, const 0} and flags forward/out-of-range refs.
module mig_operand_mux
  import mig_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  input  logic               inv,
  input  logic [N_IN-1:0]    x,
  input  logic [N_NODES-1:0] nodes,
  input  logic [ADDR_W-1:0]  k,
  output logic               val,
  output logic               fwd
);

  logic sig;

  always_comb begin
    sig = 1'b0;
    fwd = 1'b0;
    if (sel != SEL_CONST0) begin
      for (int i = 0; i < N_IN; i++) begin
        if (sel == SEL_W'(i + 1)) sig = x[i];
      end
      // Nodes at or beyond the one being computed are not yet valid.
      for (int j = 0; j < N_NODES; j++) begin
        if (sel == SEL_W'(N_IN + 1 + j)) begin
          if (ADDR_W'(j) >= k) fwd = 1'b1;
          else                 sig = nodes[j];
        end
      end
      if (sel > SEL_W'(N_IN + N_NODES)) fwd = 1'b1;
    end
    val = sig ^ inv;
  end

endmodule

// File: rtl/mig_chain_eval.sv
// Programmable MIG chain evaluator: one majority node per clock under valid/ready.
// Optional MIG_TRACE_EN exposes the node registers and the EVAL cycle count.
module mig_chain_eval
  import mig_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mig_chain_eval_if.slave    bus
`ifdef MIG_TRACE_EN
  ,
  output logic [N_NODES-1:0] node_vec,
  output logic [LEN_W:0]     cycles
`endif
);

  state_e             state_reg, state_next;
  logic [ADDR_W-1:0]  k_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               out_inv_reg;
  logic [N_IN-1:0]    x_reg;
  logic [N_NODES-1:0] node_reg;
  logic               y_reg;
  logic               err_reg;
  node_word_t         prog_ram [N_NODES];

  logic               in_ready, out_valid, accept, last;
  logic [LEN_W-1:0]   len_sat;
  node_word_t         cur_word;
  logic [2:0]         op_val, op_fwd;
  logic               maj_val;

  assign accept   = in_ready & bus.in_valid;
  assign len_sat  = (bus.cfg_len > LEN_W'(N_NODES)) ? LEN_W'(N_NODES) : bus.cfg_len;
  assign last     = ({1'b0, k_reg} == len_reg - LEN_W'(1));
  assign cur_word = prog_ram[k_reg];
  assign maj_val  = maj3(op_val[0], op_val[1], op_val[2]);

  // Program memory keeps its contents across rst; loads only land while idle.
  always_ff @(posedge clk) begin
    if (bus.prog_we && state_reg == IDLE)
      prog_ram[bus.prog_addr] <= node_word_t'(bus.prog_data);
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_op
    mig_operand_mux u_mux (
      .sel   (cur_word.op[gi].sel),
      .inv   (cur_word.op[gi].inv),
      .x     (x_reg),
      .nodes (node_reg),
      .k     (k_reg),
      .val   (op_val[gi]),
      .fwd   (op_fwd[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = (len_sat == '0) ? DONE : EVAL;
      end
      EVAL: if (last) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg       <= '0;
      len_reg     <= '0;
      out_inv_reg <= 1'b0;
      x_reg       <= '0;
      node_reg    <= '0;
      y_reg       <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      if (state_reg == IDLE && accept) begin
        k_reg       <= '0;
        len_reg     <= len_sat;
        out_inv_reg <= bus.cfg_out_inv;
        x_reg       <= bus.x;
        node_reg    <= '0;
        err_reg     <= 1'b0;
        y_reg       <= (len_sat == '0) ? bus.cfg_out_inv : 1'b0;
      end else if (state_reg == EVAL) begin
        node_reg[k_reg] <= maj_val;
        err_reg         <= err_reg | (|op_fwd);
        k_reg           <= k_reg + ADDR_W'(1);
        if (last) y_reg <= maj_val ^ out_inv_reg;
      end
    end
  end

`ifdef MIG_TRACE_EN
  logic [LEN_W:0] cycles_reg;

  always_ff @(posedge clk) begin
    if (rst)                               cycles_reg <= '0;
    else if (state_reg == IDLE && accept)  cycles_reg <= '0;
    else if (state_reg == EVAL)            cycles_reg <= cycles_reg + (LEN_W+1)'(1);
  end

  assign node_vec = node_reg;
  assign cycles   = cycles_reg;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.y         = y_reg;
  assign bus.err_fwd   = err_reg;

endmodule

// File: tb/tb_mig_chain_eval.sv
// Directed self-checking bench for mig_chain_eval (program P5, len 0, saturation,
// forward refs, backpressure, write-drop, same-cycle write and mid-evaluation reset).
module tb_mig_chain_eval;
  import mig_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mig_chain_eval_if bus();

`ifdef MIG_TRACE_EN
  logic [N_NODES-1:0] node_vec;
  logic [LEN_W:0]     cycles;
`endif

  mig_chain_eval dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef MIG_TRACE_EN
    ,
    .node_vec (node_vec),
    .cycles   (cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] w(input logic i2, input logic [3:0] s2,
                                    input logic i1, input logic [3:0] s1,
                                    input logic i0, input logic [3:0] s0);
    return {i2, s2, i1, s1, i0, s0};
  endfunction

  function automatic logic m3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Direct boolean model of program P5.
  function automatic logic p5(input logic [5:0] v);
    logic n0, n1, n2, n3, n4;
    n0 = m3(~v[1], v[2], 1'b0);
    n1 = m3(~v[0], v[1], v[4]);
    n2 = m3(v[5], n0, n1);
    n3 = m3(v[4], ~v[5], n2);
    n4 = m3(~v[3], v[5], n3);
    return n4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [2:0] addr, input logic [14:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    step();
    bus.prog_we   = 1'b0;
  endtask

  // Offer one vector (optionally with a same-cycle program write) and wait for DONE.
  task automatic run(input string tag, input logic [5:0] xv, input logic [3:0] len,
                     input logic inv, input logic pw, input logic ey, input logic ee,
                     input int elat);
    int lat;
    bus.x           = xv;
    bus.cfg_len     = len;
    bus.cfg_out_inv = inv;
    bus.in_valid    = 1'b1;
    bus.prog_we     = pw;
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.prog_we  = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    $display("[TB] %s x=%h len=%0d inv=%b -> y=%b err=%b lat=%0d", tag, xv, len, inv,
             bus.y, bus.err_fwd, lat);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " y"}, 32'(bus.y), 32'(ey));
    chk({tag, " err_fwd"}, 32'(bus.err_fwd), 32'(ee));
  endtask

  task automatic ack(input string tag);
    bus.out_ready = 1'b1;
    step();
    chk({tag, " out_valid after ack"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " in_ready after ack"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.prog_we     = 1'b0;
    bus.prog_addr   = '0;
    bus.prog_data   = '0;
    bus.cfg_len     = '0;
    bus.cfg_out_inv = 1'b0;
    bus.in_valid    = 1'b0;
    bus.x           = '0;
    bus.out_ready   = 1'b1;

    repeat (3) step();
    rst = 1'b0;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset y", 32'(bus.y), 32'd0);
    chk("reset err_fwd", 32'(bus.err_fwd), 32'd0);

    // P5 plus three pass-through nodes n5..n7 = n4 for the saturation case.
    prog(3'd0, w(0, 4'd0, 0, 4'd3, 1, 4'd2));
    prog(3'd1, w(0, 4'd5, 0, 4'd2, 1, 4'd1));
    prog(3'd2, w(0, 4'd8, 0, 4'd7, 0, 4'd6));
    prog(3'd3, w(0, 4'd9, 1, 4'd6, 0, 4'd5));
    prog(3'd4, w(0, 4'd10, 0, 4'd6, 1, 4'd4));
    prog(3'd5, w(0, 4'd0, 0, 4'd11, 0, 4'd11));
    prog(3'd6, w(0, 4'd0, 0, 4'd12, 0, 4'd12));
    prog(3'd7, w(0, 4'd0, 0, 4'd13, 0, 4'd13));

    run("p5 x00", 6'h00, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 6); ack("p5 x00");
    run("p5 x3F", 6'h3F, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 6); ack("p5 x3F");
    run("p5 x20", 6'h20, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 6); ack("p5 x20");

    for (int v = 0; v < 64; v++) begin
      run("p5 sweep", 6'(v), 4'd5, 1'b0, 1'b0, p5(6'(v)), 1'b0, 6);
      step();
    end

    run("p5 inv x3F", 6'h3F, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6); ack("p5 inv");
    run("len0 inv1", 6'h15, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1); ack("len0 inv1");
    run("len0 inv0", 6'h3F, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1); ack("len0 inv0");
    run("len15 sat", 6'h20, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 9); ack("len15 sat");
    run("len8 x00", 6'h00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 9); ack("len8 x00");
    run("len15 inv", 6'h3F, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 9); ack("len15 inv");

    // n0 = M(node2, x0, x1): the node-2 operand reads 0 and raises err_fwd.
    prog(3'd0, w(0, 4'd2, 0, 4'd1, 0, 4'd9));
    bus.out_ready = 1'b0;
    run("fwd x03", 6'h03, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = 3'd0;
        bus.prog_data = w(0, 4'd0, 0, 4'd0, 0, 4'd0);
      end
      step();
      bus.prog_we = 1'b0;
      chk("hold out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold y", 32'(bus.y), 32'd1);
      chk("hold err_fwd", 32'(bus.err_fwd), 32'd1);
      chk("hold in_ready", 32'(bus.in_ready), 32'd0);
    end
    ack("fwd hold");
    run("fwd after drop x03", 6'h03, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 2); ack("fwd x03 b");
    run("fwd after drop x01", 6'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2); ack("fwd x01");

    // Restore n0 in the same cycle the vector is accepted.
    bus.prog_addr = 3'd0;
    bus.prog_data = w(0, 4'd0, 0, 4'd3, 1, 4'd2);
    run("same-cycle write", 6'h3F, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 6); ack("same-cycle");
    run("restored x00", 6'h00, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 6); ack("restored");

    // Abort in the second EVAL cycle.
    bus.x        = 6'h3F;
    bus.cfg_len  = 4'd5;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort y", 32'(bus.y), 32'd0);
    step();
    chk("abort no result", 32'(bus.out_valid), 32'd0);
    run("post-abort x20", 6'h20, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 6); ack("post-abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
